alu_muldiv: RTL and testbench

ALU_MULDIV -- requirements
Module: alu_muldiv

---
 rtl/alu_muldiv.sv | 187 ++++++++++++++++++
 tb/tb_alu_muldiv.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/alu_muldiv.sv
// Single-cycle ALU with a sequential multiply/divide unit and its HI/LO result registers.
// Multiply and divide run one bit per cycle on operand magnitudes, then sign-correct on the way out.
module alu_muldiv #(
  parameter int WIDTH = 32,
  parameter int SHW   = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [4:0]       ALUOp,
  input  logic [SHW-1:0]   shamt,
  input  logic [15:0]      offset,
  input  logic             start,
  output logic [WIDTH-1:0] C,
  output logic             zero,
  output logic             ovf,
  output logic             busy,
  output logic             done
);

  localparam logic [4:0] OP_ADDU = 5'd0,  OP_SUBU = 5'd1,  OP_ADD  = 5'd2,  OP_SUB  = 5'd3;
  localparam logic [4:0] OP_OR   = 5'd4,  OP_AND  = 5'd5,  OP_LUI  = 5'd6,  OP_SLL  = 5'd7;
  localparam logic [4:0] OP_SRL  = 5'd8,  OP_SRA  = 5'd9,  OP_EQL  = 5'd10, OP_BNE  = 5'd11;
  localparam logic [4:0] OP_SLT  = 5'd12, OP_SW   = 5'd13, OP_LW   = 5'd14, OP_SLTU = 5'd15;
  localparam logic [4:0] OP_XOR  = 5'd16, OP_NOR  = 5'd17, OP_MULT = 5'd18, OP_MULTU = 5'd19;
  localparam logic [4:0] OP_DIV  = 5'd20, OP_DIVU = 5'd21, OP_MFHI = 5'd22, OP_MFLO = 5'd23;
  localparam logic [4:0] OP_MTHI = 5'd24, OP_MTLO = 5'd25;
  localparam logic [SHW:0] CNT_LAST = (SHW+1)'(WIDTH);

  typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d;
  logic [WIDTH-1:0] acc_hi_q, acc_hi_d, acc_lo_q, acc_lo_d;
  logic [WIDTH-1:0] mag_b_q, mag_b_d, a_q, a_d;
  logic [SHW:0]     count_q, count_d;
  logic             is_mul_q, is_mul_d, neg_a_q, neg_a_d, neg_b_q, neg_b_d, b_zero_q, b_zero_d;

  logic [WIDTH-1:0]   sum, diff, off_ext;
  logic               md_op, sgn_op;
  logic [WIDTH:0]     msum, shifted, ddiff;
  logic [2*WIDTH-1:0] prod, prod_fix;

  assign sum     = A + B;
  assign diff    = A - B;
  assign off_ext = {{(WIDTH-16){offset[15]}}, offset};

  always_comb begin
    C    = '0;
    zero = 1'b0;
    ovf  = 1'b0;
    case (ALUOp)
      OP_ADDU: C = sum;
      OP_SUBU: C = diff;
      OP_ADD: begin
        C   = sum;
        ovf = (A[WIDTH-1] == B[WIDTH-1]) && (sum[WIDTH-1] != A[WIDTH-1]);
      end
      OP_SUB: begin
        C   = diff;
        ovf = (A[WIDTH-1] != B[WIDTH-1]) && (diff[WIDTH-1] != A[WIDTH-1]);
      end
      OP_OR:   C = A | B;
      OP_AND:  C = A & B;
      OP_LUI:  C = {B[15:0], {(WIDTH-16){1'b0}}};
      OP_SLL:  C = B << shamt;
      OP_SRL:  C = B >> shamt;
      OP_SRA:  C = $signed(B) >>> shamt;
      OP_EQL:  zero = (A == B);
      OP_BNE:  zero = (A != B);
      OP_SLT:  C = {{(WIDTH-1){1'b0}}, $signed(A) < $signed(B)};
      OP_SW, OP_LW: C = A + off_ext;
      OP_SLTU: C = {{(WIDTH-1){1'b0}}, A < B};
      OP_XOR:  C = A ^ B;
      OP_NOR:  C = ~(A | B);
      OP_MFHI: C = hi_q;
      OP_MFLO: C = lo_q;
      default: C = '0;
    endcase
  end

  assign md_op  = (ALUOp == OP_MULT) || (ALUOp == OP_MULTU) || (ALUOp == OP_DIV) || (ALUOp == OP_DIVU);
  assign sgn_op = (ALUOp == OP_MULT) || (ALUOp == OP_DIV);

  // Multiply: add into the upper half, shift the pair right. Divide: acc_hi is the partial
  // remainder, acc_lo shifts dividend bits out of its top and quotient bits into its bottom.
  assign msum     = {1'b0, acc_hi_q} + (acc_lo_q[0] ? {1'b0, mag_b_q} : '0);
  assign shifted  = {acc_hi_q, acc_lo_q[WIDTH-1]};
  assign ddiff    = shifted - {1'b0, mag_b_q};
  assign prod     = {acc_hi_q, acc_lo_q};
  assign prod_fix = (neg_a_q ^ neg_b_q) ? -prod : prod;

  always_comb begin
    state_d  = state_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    acc_hi_d = acc_hi_q;
    acc_lo_d = acc_lo_q;
    mag_b_d  = mag_b_q;
    a_d      = a_q;
    count_d  = count_q;
    is_mul_d = is_mul_q;
    neg_a_d  = neg_a_q;
    neg_b_d  = neg_b_q;
    b_zero_d = b_zero_q;
    case (state_q)
      RUN: begin
        if (count_q == CNT_LAST) begin
          state_d = FIN;
          if (is_mul_q) begin
            hi_d = prod_fix[2*WIDTH-1:WIDTH];
            lo_d = prod_fix[WIDTH-1:0];
          end else if (b_zero_q) begin
            hi_d = a_q;
            lo_d = '1;
          end else begin
            hi_d = neg_a_q ? -acc_hi_q : acc_hi_q;
            lo_d = (neg_a_q ^ neg_b_q) ? -acc_lo_q : acc_lo_q;
          end
        end else begin
          count_d = count_q + (SHW+1)'(1);
          if (is_mul_q) begin
            {acc_hi_d, acc_lo_d} = {msum, acc_lo_q[WIDTH-1:1]};
          end else begin
            acc_hi_d = ddiff[WIDTH] ? shifted[WIDTH-1:0] : ddiff[WIDTH-1:0];
            acc_lo_d = {acc_lo_q[WIDTH-2:0], ~ddiff[WIDTH]};
          end
        end
      end
      default: begin
        // FIN is not busy, so it accepts a new request just like IDLE.
        state_d = IDLE;
        if (start && md_op) begin
          state_d  = RUN;
          neg_a_d  = sgn_op && A[WIDTH-1];
          neg_b_d  = sgn_op && B[WIDTH-1];
          acc_hi_d = '0;
          acc_lo_d = (sgn_op && A[WIDTH-1]) ? -A : A;
          mag_b_d  = (sgn_op && B[WIDTH-1]) ? -B : B;
          a_d      = A;
          b_zero_d = (B == '0);
          is_mul_d = (ALUOp == OP_MULT) || (ALUOp == OP_MULTU);
          count_d  = '0;
        end else if (start && ALUOp == OP_MTHI) begin
          hi_d = A;
        end else if (start && ALUOp == OP_MTLO) begin
          lo_d = A;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      hi_q     <= '0;
      lo_q     <= '0;
      acc_hi_q <= '0;
      acc_lo_q <= '0;
      mag_b_q  <= '0;
      a_q      <= '0;
      count_q  <= '0;
      is_mul_q <= 1'b0;
      neg_a_q  <= 1'b0;
      neg_b_q  <= 1'b0;
      b_zero_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      acc_hi_q <= acc_hi_d;
      acc_lo_q <= acc_lo_d;
      mag_b_q  <= mag_b_d;
      a_q      <= a_d;
      count_q  <= count_d;
      is_mul_q <= is_mul_d;
      neg_a_q  <= neg_a_d;
      neg_b_q  <= neg_b_d;
      b_zero_q <= b_zero_d;
    end
  end

  assign busy = (state_q == RUN);
  assign done = (state_q == FIN);

endmodule

// File: tb/tb_alu_muldiv.sv
// Bench for alu_muldiv: combinational ALU checks plus a HI/LO scoreboard for multiply/divide.
module tb_alu_muldiv;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [W-1:0] A, B, C;
  logic [4:0]   ALUOp;
  logic [4:0]   shamt;
  logic [15:0]  offset;
  logic         start, zero, ovf, busy, done;

  int checks = 0;
  int errors = 0;
  logic [W-1:0] exp_q[$];

  alu_muldiv #(.WIDTH(W), .SHW(5)) dut (
    .clk(clk), .rst_n(rst_n), .A(A), .B(B), .ALUOp(ALUOp), .shamt(shamt),
    .offset(offset), .start(start), .C(C), .zero(zero), .ovf(ovf), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference results from native SV arithmetic, with the defined corner cases spelled out.
  task automatic model(input logic [4:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                       output logic [W-1:0] hi, output logic [W-1:0] lo);
    longint sa, sb, p;
    longint unsigned ua, ub, up;
    int si, sj;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'd0, a};
    ub = {32'd0, b};
    hi = '0;
    lo = '0;
    case (op)
      5'd18: begin p = sa * sb; hi = p[63:32]; lo = p[31:0]; end
      5'd19: begin up = ua * ub; hi = up[63:32]; lo = up[31:0]; end
      5'd20: begin
        if (b == 0) begin hi = a; lo = '1; end
        else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin hi = '0; lo = a; end
        else begin si = $signed(a); sj = $signed(b); lo = si / sj; hi = si % sj; end
      end
      default: begin
        if (b == 0) begin hi = a; lo = '1; end
        else begin lo = a / b; hi = a % b; end
      end
    endcase
  endtask

  task automatic comb_check(input string tag, input logic [4:0] op, input logic [W-1:0] a,
                            input logic [W-1:0] b, input logic [W-1:0] exp_c);
    @(negedge clk);
    ALUOp = op; A = a; B = b;
    #1 check(tag, C, exp_c);
  endtask

  task automatic run_md(input string tag, input logic [4:0] op, input logic [W-1:0] a,
                        input logic [W-1:0] b, input logic [W-1:0] exp_hi, input logic [W-1:0] exp_lo);
    int busy_cnt;
    int i;
    logic [W-1:0] e;
    exp_q.push_back(exp_hi);
    exp_q.push_back(exp_lo);
    @(negedge clk);
    ALUOp = op; A = a; B = b; start = 1'b1;
    @(negedge clk);
    busy_cnt = 0;
    i = 0;
    while (!done && i < 100) begin
      if (busy) busy_cnt++;
      // Scramble operands and fire an MTHI while busy; neither may disturb the result.
      A = $urandom; B = $urandom;
      if (i == 3) begin ALUOp = 5'd24; start = 1'b1; end
      else begin ALUOp = op; start = 1'b0; end
      i++;
      @(negedge clk);
    end
    start = 1'b0;
    check({tag, "_done"}, {31'd0, done}, 32'd1);
    check({tag, "_busy_cycles"}, busy_cnt, W + 1);
    e = exp_q.pop_front();
    ALUOp = 5'd22;
    #1 check({tag, "_hi"}, C, e);
    e = exp_q.pop_front();
    ALUOp = 5'd23;
    #1 check({tag, "_lo"}, C, e);
    @(negedge clk);
    check({tag, "_done_pulse"}, {31'd0, done}, 32'd0);
  endtask

  initial begin
    logic [W-1:0] ra, rb, mh, ml;
    logic [4:0] rop;
    int done_seen;
    rst_n = 1'b0; A = '0; B = '0; ALUOp = '0; shamt = '0; offset = '0; start = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    ALUOp = 5'd22;
    #1 check("rst_hi", C, 32'd0);
    ALUOp = 5'd23;
    #1 check("rst_lo", C, 32'd0);
    rst_n = 1'b1;

    comb_check("add_c", 5'd2, 32'h7FFF_FFFF, 32'd1, 32'h8000_0000);
    check("add_ovf", {31'd0, ovf}, 32'd1);
    comb_check("addu_c", 5'd0, 32'h7FFF_FFFF, 32'd1, 32'h8000_0000);
    check("addu_ovf", {31'd0, ovf}, 32'd0);
    comb_check("sub_c", 5'd3, 32'h8000_0000, 32'd1, 32'h7FFF_FFFF);
    check("sub_ovf", {31'd0, ovf}, 32'd1);
    comb_check("eql_c", 5'd10, 32'h1234_5678, 32'h1234_5678, 32'd0);
    check("eql_zero", {31'd0, zero}, 32'd1);
    comb_check("and_c", 5'd5, 32'h1234_5678, 32'h1234_5678, 32'h1234_5678);
    check("and_zero", {31'd0, zero}, 32'd0);
    comb_check("bne_c", 5'd11, 32'd1, 32'd2, 32'd0);
    check("bne_zero", {31'd0, zero}, 32'd1);
    comb_check("slt", 5'd12, 32'hFFFF_FFFF, 32'd1, 32'd1);
    comb_check("sltu", 5'd15, 32'hFFFF_FFFF, 32'd1, 32'd0);
    comb_check("lui", 5'd6, 32'd0, 32'h0000_1234, 32'h1234_0000);
    shamt = 5'd4;
    comb_check("sra", 5'd9, 32'd0, 32'h8000_0000, 32'hF800_0000);
    comb_check("srl", 5'd8, 32'd0, 32'h8000_0000, 32'h0800_0000);
    comb_check("sll", 5'd7, 32'd0, 32'h8000_0001, 32'h0000_0010);
    offset = 16'hFFFC;
    comb_check("lw", 5'd14, 32'h0000_0100, 32'd0, 32'h0000_00FC);
    comb_check("nor", 5'd17, 32'hF0F0_0000, 32'h0000_000F, 32'h0F0F_FFF0);
    comb_check("rsvd", 5'd30, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0);

    @(negedge clk);
    ALUOp = 5'd2; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("alu_start_busy", {31'd0, busy}, 32'd0);

    @(negedge clk);
    ALUOp = 5'd24; A = 32'hDEAD_BEEF; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("mthi_busy", {31'd0, busy}, 32'd0);
    check("mthi_done", {31'd0, done}, 32'd0);
    ALUOp = 5'd22;
    #1 check("mthi_read", C, 32'hDEAD_BEEF);

    run_md("mult", 5'd18, 32'hFFFF_FFFE, 32'h0000_0003, 32'hFFFF_FFFF, 32'hFFFF_FFFA);
    run_md("multu", 5'd19, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001);
    run_md("div", 5'd20, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    run_md("divu0", 5'd21, 32'h0000_1234, 32'h0000_0000, 32'h0000_1234, 32'hFFFF_FFFF);
    run_md("div0", 5'd20, 32'hFFFF_FF00, 32'h0000_0000, 32'hFFFF_FF00, 32'hFFFF_FFFF);
    run_md("divmin", 5'd20, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000);

    for (int k = 0; k < 8; k++) begin
      rop = 5'($urandom_range(18, 21));
      ra = $urandom;
      rb = (k % 4 == 0) ? 32'd0 : (k % 4 == 1) ? 32'($urandom_range(1, 9)) : $urandom;
      model(rop, ra, rb, mh, ml);
      run_md($sformatf("rnd%0d", k), rop, ra, rb, mh, ml);
    end

    // Reset mid-run: MTLO at cycle 5 is ignored, reset at cycle 10 aborts with HI/LO cleared.
    @(negedge clk);
    ALUOp = 5'd18; A = 32'h0001_0000; B = 32'h0001_0000; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int c = 1; c < 10; c++) begin
      if (c == 5) begin ALUOp = 5'd25; A = 32'h1234_5678; start = 1'b1; end
      else begin ALUOp = 5'd18; start = 1'b0; end
      @(negedge clk);
    end
    start = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_done", {31'd0, done}, 32'd0);
    rst_n = 1'b1;
    done_seen = 0;
    repeat (40) begin
      @(negedge clk);
      if (done) done_seen++;
    end
    check("abort_no_done", done_seen, 0);
    ALUOp = 5'd22;
    #1 check("abort_hi", C, 32'd0);
    ALUOp = 5'd23;
    #1 check("abort_lo", C, 32'd0);

    run_md("post_rst", 5'd19, 32'h0000_0010, 32'h0000_0010, 32'd0, 32'h0000_0100);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
